// File: rtl/ped_request_latch.sv
// Pedestrian request latch: turns the debounced button level into a held crossing
// request, escalates it to urgent after a long wait, and locks out re-requests after an ack.
module ped_request_latch #(
   parameter int LOCKOUT_CYCLES  = 16,
   parameter int MAX_WAIT_CYCLES = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       buton,
   input  logic       ack,
   output logic       req,
   output logic       urgent,
   output logic       busy,
   output logic       press_pulse,
   output logic [1:0] state
);

   // state   | meaning
   // IDLE    | no request outstanding, waiting for a fresh button rise
   // PENDING | request latched, waiting for ack from the traffic FSM
   // LOCKOUT | request served, new presses ignored until lock_cnt expires
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      LOCKOUT = 2'd2
   } state_t;

   localparam int WW = $clog2(MAX_WAIT_CYCLES + 1);
   // A zero-length lockout would give a zero-width counter; keep one bit so it elaborates.
   localparam int LW = (LOCKOUT_CYCLES > 0) ? $clog2(LOCKOUT_CYCLES + 1) : 1;
   localparam logic [WW-1:0] WAIT_MAX  = WW'(MAX_WAIT_CYCLES);
   localparam logic [LW-1:0] LOCK_LOAD = (LOCKOUT_CYCLES > 0) ? LW'(LOCKOUT_CYCLES - 1) : '0;

   state_t        state_q, state_d;
   logic [WW-1:0] wait_q, wait_d;
   logic [LW-1:0] lock_q, lock_d;
   logic          buton_q;
   logic          pulse_q;
   logic          rise;

   assign rise = buton & ~buton_q;

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      lock_d  = lock_q;
      case (state_q)
         IDLE: begin
            if (rise) begin
               state_d = PENDING;
               wait_d  = '0;
            end
         end
         PENDING: begin
            if (ack) begin
               wait_d = '0;
               if (LOCKOUT_CYCLES == 0) begin
                  state_d = IDLE;
               end else begin
                  state_d = LOCKOUT;
                  lock_d  = LOCK_LOAD;
               end
            end else if (wait_q != WAIT_MAX) begin
               wait_d = wait_q + WW'(1);
            end
         end
         LOCKOUT: begin
            if (lock_q == '0) begin
               state_d = IDLE;
            end else begin
               lock_d = lock_q - LW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            wait_d  = '0;
            lock_d  = '0;
         end
      endcase
   end

   // buton_q resets high so a button held through reset never looks like a fresh press.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         wait_q  <= '0;
         lock_q  <= '0;
         buton_q <= 1'b1;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         lock_q  <= lock_d;
         buton_q <= buton;
         pulse_q <= rise;
      end
   end

   assign req         = (state_q == PENDING);
   assign urgent      = (state_q == PENDING) && (wait_q == WAIT_MAX);
   assign busy        = (state_q == LOCKOUT);
   assign press_pulse = pulse_q;
   assign state       = state_q;

endmodule

// File: tb/tb_ped_request_latch.sv
// Directed bench for ped_request_latch: one instance with a 4-cycle lockout and one
// with no lockout, each step queues its expected outputs and checks them after the edge.
module tb_ped_request_latch;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       buton = 1'b0;
   logic       ack = 1'b0;
   logic       buton0 = 1'b0;
   logic       ack0 = 1'b0;
   logic       req, urgent, busy, press_pulse;
   logic [1:0] state;
   logic       req0, urgent0, busy0, press_pulse0;
   logic [1:0] state0;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      tag;
      bit         sel;
      logic [5:0] exp;
   } sb_t;

   sb_t sb[$];

   always #5 clk = ~clk;

   ped_request_latch #(.LOCKOUT_CYCLES(4), .MAX_WAIT_CYCLES(8)) dut (
      .clk(clk), .rst(rst), .buton(buton), .ack(ack),
      .req(req), .urgent(urgent), .busy(busy),
      .press_pulse(press_pulse), .state(state)
   );

   ped_request_latch #(.LOCKOUT_CYCLES(0), .MAX_WAIT_CYCLES(8)) dut0 (
      .clk(clk), .rst(rst), .buton(buton0), .ack(ack0),
      .req(req0), .urgent(urgent0), .busy(busy0),
      .press_pulse(press_pulse0), .state(state0)
   );

   // expected vector layout: {req, urgent, busy, press_pulse, state}
   function automatic logic [5:0] mk(input logic rq, input logic ug, input logic bz,
                                     input logic pp, input logic [1:0] st);
      return {rq, ug, bz, pp, st};
   endfunction

   task automatic check_front();
      sb_t        item;
      logic [5:0] obs;
      item = sb.pop_front();
      obs  = item.sel ? {req0, urgent0, busy0, press_pulse0, state0}
                      : {req, urgent, busy, press_pulse, state};
      checks++;
      assert (obs === item.exp)
      else begin
         errors++;
         $error("FAIL %s: observed {req,urg,busy,pp,st}=%b expected %b", item.tag, obs, item.exp);
      end
   endtask

   task automatic step(input bit sel, input logic b, input logic a, input logic r,
                       input string tag, input logic [5:0] e);
      @(negedge clk);
      if (sel) begin
         buton0 = b;
         ack0   = a;
      end else begin
         buton = b;
         ack   = a;
      end
      rst = r;
      sb.push_back('{tag, sel, e});
      @(posedge clk);
      #1;
      check_front();
   endtask

   initial begin
      // reset
      step(0, 0, 0, 1, "reset_a", mk(0, 0, 0, 0, 0));
      step(0, 0, 0, 1, "reset_b", mk(0, 0, 0, 0, 0));
      step(1, 0, 0, 0, "reset_dut0", mk(0, 0, 0, 0, 0));

      // basic request, ack at k+3, lockout through k+6, idle after k+7
      step(0, 1, 0, 0, "basic_k", mk(1, 0, 0, 1, 1));
      step(0, 1, 0, 0, "basic_k1", mk(1, 0, 0, 0, 1));
      step(0, 1, 0, 0, "basic_k2", mk(1, 0, 0, 0, 1));
      step(0, 1, 1, 0, "basic_ack", mk(0, 0, 1, 0, 2));
      step(0, 1, 0, 0, "basic_lock4", mk(0, 0, 1, 0, 2));
      step(0, 1, 0, 0, "basic_lock5", mk(0, 0, 1, 0, 2));
      step(0, 1, 0, 0, "basic_lock6", mk(0, 0, 1, 0, 2));
      step(0, 1, 0, 0, "basic_idle7", mk(0, 0, 0, 0, 0));
      step(0, 1, 0, 0, "held_no_req", mk(0, 0, 0, 0, 0));
      step(0, 0, 0, 0, "release", mk(0, 0, 0, 0, 0));
      step(0, 1, 0, 0, "repress_req", mk(1, 0, 0, 1, 1));

      // urgent escalation: urgent from wait_cnt==8 onward, cleared by ack at j+12
      for (int i = 1; i <= 11; i++)
         step(0, 0, 0, 0, $sformatf("urgent_j%0d", i), mk(1, (i >= 8), 0, 0, 1));
      step(0, 0, 1, 0, "urgent_ack", mk(0, 0, 1, 0, 2));

      // press during lockout pulses only; held button into idle does not request
      step(0, 1, 0, 0, "lock_press", mk(0, 0, 1, 1, 2));
      step(0, 1, 0, 0, "lock_hold1", mk(0, 0, 1, 0, 2));
      step(0, 1, 0, 0, "lock_hold2", mk(0, 0, 1, 0, 2));
      step(0, 1, 0, 0, "lock_end_held", mk(0, 0, 0, 0, 0));
      step(0, 1, 0, 0, "idle_held", mk(0, 0, 0, 0, 0));
      step(0, 0, 0, 0, "idle_release", mk(0, 0, 0, 0, 0));
      step(0, 1, 0, 0, "idle_press", mk(1, 0, 0, 1, 1));

      // rise and ack together: ack wins, no queued request
      step(0, 0, 0, 0, "sim_pend", mk(1, 0, 0, 0, 1));
      step(0, 1, 1, 0, "sim_rise_ack", mk(0, 0, 1, 1, 2));
      step(0, 0, 0, 0, "sim_lock1", mk(0, 0, 1, 0, 2));
      step(0, 0, 0, 0, "sim_lock2", mk(0, 0, 1, 0, 2));
      step(0, 0, 0, 0, "sim_lock3", mk(0, 0, 1, 0, 2));
      step(0, 0, 0, 0, "sim_idle", mk(0, 0, 0, 0, 0));
      step(0, 0, 0, 0, "sim_no_second", mk(0, 0, 0, 0, 0));

      // ack while idle
      step(0, 0, 1, 0, "idle_ack", mk(0, 0, 0, 0, 0));
      step(0, 0, 0, 0, "idle_ack_after", mk(0, 0, 0, 0, 0));

      // button held through reset
      step(0, 1, 0, 1, "rst_held", mk(0, 0, 0, 0, 0));
      step(0, 1, 0, 0, "rst_held_after", mk(0, 0, 0, 0, 0));
      step(0, 1, 0, 0, "rst_held_after2", mk(0, 0, 0, 0, 0));

      // reset mid-PENDING with wait_cnt=5
      step(0, 0, 0, 0, "rp_release", mk(0, 0, 0, 0, 0));
      step(0, 1, 0, 0, "rp_press", mk(1, 0, 0, 1, 1));
      for (int i = 1; i <= 5; i++)
         step(0, 1, 0, 0, $sformatf("rp_wait%0d", i), mk(1, 0, 0, 0, 1));
      step(0, 1, 0, 1, "rp_reset", mk(0, 0, 0, 0, 0));
      step(0, 1, 0, 0, "rp_after", mk(0, 0, 0, 0, 0));

      // reset mid-LOCKOUT
      step(0, 0, 0, 0, "rl_release", mk(0, 0, 0, 0, 0));
      step(0, 1, 0, 0, "rl_press", mk(1, 0, 0, 1, 1));
      step(0, 1, 1, 0, "rl_ack", mk(0, 0, 1, 0, 2));
      step(0, 1, 0, 1, "rl_reset", mk(0, 0, 0, 0, 0));
      step(0, 0, 0, 0, "rl_after", mk(0, 0, 0, 0, 0));

      // zero-lockout instance: ack returns straight to idle, next rise re-requests
      step(1, 1, 0, 0, "z_press", mk(1, 0, 0, 1, 1));
      step(1, 1, 0, 0, "z_pend", mk(1, 0, 0, 0, 1));
      step(1, 0, 1, 0, "z_ack_idle", mk(0, 0, 0, 0, 0));
      step(1, 1, 0, 0, "z_rereq", mk(1, 0, 0, 1, 1));
      step(1, 1, 1, 0, "z_ack2", mk(0, 0, 0, 0, 0));
      step(1, 0, 0, 0, "z_idle", mk(0, 0, 0, 0, 0));

      checks++;
      assert (sb.size() == 0)
      else begin
         errors++;
         $error("FAIL sb_drain: observed %0d entries left expected 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ped_request_latch.md
Name: ped_request_latch

Overview:
- Downstream of the push-button debouncer (sync flip-flop + debounce counter producing the clean `buton` level).
- Converts the debounced pedestrian button level into a latched crossing request for the intersection traffic-light FSM.
- Holds the request until the FSM acknowledges it, escalates to `urgent` if it waits too long, then enforces a lockout so a fresh press cannot re-request immediately.

Parameters:
- LOCKOUT_CYCLES, 16: clocks during which new presses are ignored after an ack. 0 = no lockout.
- MAX_WAIT_CYCLES, 64: pending clocks after which `urgent` asserts. Must be >= 1.
- Counter widths: $clog2(param+1) of the respective parameter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- buton  in  1  debounced button level from the debouncer counter stage. Already synchronous to clk.
- ack  in  1  traffic FSM grants the pedestrian phase. Level; sampled each edge.
- req  out  1  pending crossing request.
- urgent  out  1  request has waited MAX_WAIT_CYCLES or more.
- busy  out  1  lockout active.
- press_pulse  out  1  one-clock pulse per detected rising edge of `buton`, in every state.
- state  out  2  debug: 0 IDLE, 1 PENDING, 2 LOCKOUT.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: state=IDLE; req=0; urgent=0; busy=0; press_pulse=0; wait_cnt=0; lock_cnt=0.
  - buton_q (previous-sample register) resets to 1. A button held through reset does not produce a request; a release then press is required.
- Edge detect:
  - rise = buton & ~buton_q, evaluated at each edge; buton_q <= buton every edge.
  - press_pulse <= rise, so it is high for the clock after the sampling edge.
- All outputs are registered or decoded from registered state. Latency from sampling edge to output is 1 clock.
- IDLE:
  - req=0, busy=0.
  - rise -> PENDING, wait_cnt<=0.
  - ack ignored.
- PENDING:
  - req=1.
  - wait_cnt increments every clock and saturates at MAX_WAIT_CYCLES. urgent = (wait_cnt == MAX_WAIT_CYCLES).
  - Further rises only pulse press_pulse; state and counters are unaffected.
  - ack=1 -> LOCKOUT with lock_cnt <= LOCKOUT_CYCLES-1; or -> IDLE if LOCKOUT_CYCLES==0.
  - wait_cnt <= 0 on exit; req and urgent drop the clock after the ack edge.
  - ack and rise on the same edge: ack wins, the rise is not queued.
- LOCKOUT:
  - busy=1, req=0, urgent=0. Rises and ack ignored.
  - lock_cnt==0 at an edge -> IDLE; otherwise lock_cnt decrements.
  - busy is therefore high for exactly LOCKOUT_CYCLES clocks.
  - A button held high across the lockout end does not request; a new rise is needed.
- rst asserted in any state overrides everything at that edge: all registers go to reset values and any pending request is discarded.
- state encoding 3 is illegal; it recovers to IDLE on the next edge.

Test Plan (LOCKOUT_CYCLES=4, MAX_WAIT_CYCLES=8):
- Basic request: buton 0->1 before edge k, ack=0 -> press_pulse=1 and req=1 after edge k. ack=1 at edge k+3 -> req=0 and busy=1 after k+3. busy stays high through edge k+6, busy=0 and state=IDLE after edge k+7.
- Urgent escalation: request pending, no ack -> wait_cnt 0..8, urgent=1 after edge k+8 and stays 1. ack at k+12 -> urgent=0 and req=0 after k+12.
- Lockout and held button:
  - Re-press during LOCKOUT -> press_pulse pulses, req stays 0, state=LOCKOUT.
  - Button held high from lockout into IDLE -> req stays 0.
  - Release then press -> req=1 one clock after the rise.
- Simultaneous events: in PENDING, rise and ack on the same edge -> LOCKOUT, req=0, no second request after the lockout. ack while IDLE -> no change.
- Reset cases:
  - buton held 1 during and after rst -> no press_pulse, req=0.
  - rst mid-PENDING with wait_cnt=5 -> all outputs 0 next clock.
  - rst mid-LOCKOUT -> busy=0 next clock.
- LOCKOUT_CYCLES=0 variant: ack in PENDING -> IDLE directly, busy never asserts, a rise on the next edge re-requests.
